// File: rtl/fast_pkg.sv
// fast_pkg: shared constants, word layout and helpers for the FAST keypoint
// transmit path.
//   Keypoint word : {KP_TAG[3:0], score[7:0], x[9:0], y[9:0]}
//   Trailer word  : {TRL_TAG[3:0], drop, 11'b0, count[15:0]}, sent with tlast
package fast_pkg;

  localparam int unsigned AXIS_W   = 32;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned SCORE_W  = 8;
  localparam int unsigned KPCNT_W  = 16;

  localparam logic [3:0] KP_TAG  = 4'h0;
  localparam logic [3:0] TRL_TAG = 4'hF;

  // Field offsets within the 32-bit stream word
  localparam int unsigned TAG_LSB      = 28;
  localparam int unsigned KP_SCORE_LSB = 20;
  localparam int unsigned KP_X_LSB     = 10;
  localparam int unsigned KP_Y_LSB     = 0;
  localparam int unsigned TRL_DROP_BIT = 27;
  localparam int unsigned TRL_CNT_LSB  = 0;

  // Pixels closer than this to any image edge have no complete 7x7 patch
  localparam int unsigned BORDER_MARGIN = 3;

  // One queued stream beat
  typedef struct packed {
    logic              last;
    logic [AXIS_W-1:0] data;
  } axis_word_t;

  function automatic axis_word_t kp_word(input logic [SCORE_W-1:0] score,
                                         input logic [COORD_W-1:0] x,
                                         input logic [COORD_W-1:0] y);
    axis_word_t w;
    w.last = 1'b0;
    w.data = (AXIS_W'(KP_TAG) << TAG_LSB)
           | (AXIS_W'(score)  << KP_SCORE_LSB)
           | (AXIS_W'(x)      << KP_X_LSB)
           | (AXIS_W'(y)      << KP_Y_LSB);
    return w;
  endfunction

  function automatic axis_word_t trl_word(input logic               drop,
                                          input logic [KPCNT_W-1:0] count);
    axis_word_t w;
    w.last = 1'b1;
    w.data = (AXIS_W'(TRL_TAG) << TAG_LSB)
           | (AXIS_W'(drop)    << TRL_DROP_BIT)
           | (AXIS_W'(count)   << TRL_CNT_LSB);
    return w;
  endfunction

endpackage

// File: rtl/fast_sync_fifo.sv
// fast_sync_fifo: single-clock queue of {tlast, tdata} stream words.
// Besides the registered occupancy it exposes, combinationally, the word that
// will be at the head after this cycle's pop so the caller can keep a
// registered copy of the head without a bubble between beats.
//   clk, rst      clock, synchronous active-high reset
//   wr_en/wr_data push (ignored when full)
//   rd_en         pop the current head (ignored when empty)
//   nxt_data_c    head word after this cycle's pop
//   nxt_avail_c   queue still holds a word after this cycle's pop
//   count         registered occupancy, 0..DEPTH
module fast_sync_fifo
  import fast_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  axis_word_t               wr_data,
  input  logic                     rd_en,
  output axis_word_t               nxt_data_c,
  output logic                     nxt_avail_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  axis_word_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] nxt_rd_c;
  logic          do_wr_c;
  logic          do_rd_c;

  // Qualified push/pop and look-ahead of the head
  always_comb begin
    do_wr_c     = wr_en && (count != CW'(DEPTH));
    do_rd_c     = rd_en && (count != '0);
    nxt_rd_c    = do_rd_c ? rd_ptr + AW'(1) : rd_ptr;
    nxt_avail_c = (count - CW'(do_rd_c)) != '0;
    nxt_data_c  = mem[nxt_rd_c];
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= nxt_rd_c;
      count  <= count + CW'(do_wr_c) - CW'(do_rd_c);
    end
  end

  // Storage
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/fast_kp_stream_tx.sv
// fast_kp_stream_tx: queues accepted FAST keypoints and streams them to DMA
// as 32-bit AXI4-Stream words, closing each frame with a tlast trailer that
// carries the frame's keypoint count and a drop flag.
// Optional feature macro: FAST_TX_BORDER_MASK_EN discards keypoints within
// BORDER_MARGIN pixels of the image edge before they are counted.
//   clk, rst       clock, synchronous active-high reset
//   ce             detector-side enable qualifying all kp_* inputs
//   kp_vld/kp_flag result valid / pixel is a corner
//   kp_score       corner score
//   kp_xy          {x, y} of the patch centre
//   kp_frame_end   last result of the frame
//   m_axis_*       keypoint/trailer stream (tdata, tvalid, tready, tlast)
//   tx_overrun     sticky: a trailer was lost because the queue was full
module fast_kp_stream_tx
  import fast_pkg::*;
#(
  parameter int unsigned COL_NUM     = 640,
  parameter int unsigned ROW_NUM     = 480,
  parameter int unsigned FIFO_DEPTH  = 256,
  parameter int unsigned SCORE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   kp_vld,
  input  logic                   kp_flag,
  input  logic [SCORE_WIDTH-1:0] kp_score,
  input  logic [2*COORD_W-1:0]   kp_xy,
  input  logic                   kp_frame_end,
  output logic [AXIS_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   tx_overrun
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // Elaboration-time guards on the configuration
  if (SCORE_WIDTH != SCORE_W) begin : g_bad_score
    $error("fast_kp_stream_tx: SCORE_WIDTH must be 8");
  end
  if (FIFO_DEPTH < 4 || FIFO_DEPTH > 1024 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fast_kp_stream_tx: FIFO_DEPTH must be a power of two in 4..1024");
  end
  if (COL_NUM > (1 << COORD_W) || ROW_NUM > (1 << COORD_W) ||
      COL_NUM <= 2 * BORDER_MARGIN || ROW_NUM <= 2 * BORDER_MARGIN) begin : g_bad_dims
    $error("fast_kp_stream_tx: image dimensions do not fit the coordinate fields");
  end

  logic [COORD_W-1:0] kp_x_c;
  logic [COORD_W-1:0] kp_y_c;
  logic               in_border_c;

  assign kp_x_c = kp_xy[2*COORD_W-1 -: COORD_W];
  assign kp_y_c = kp_xy[COORD_W-1:0];

`ifdef FAST_TX_BORDER_MASK_EN
  localparam logic [COORD_W-1:0] C_MIN = COORD_W'(BORDER_MARGIN);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(COL_NUM - 1 - BORDER_MARGIN);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(ROW_NUM - 1 - BORDER_MARGIN);

  // Only centres with a full patch inside the image are kept
  assign in_border_c = (kp_x_c >= C_MIN) && (kp_x_c <= X_MAX) &&
                       (kp_y_c >= C_MIN) && (kp_y_c <= Y_MAX);
`else
  assign in_border_c = 1'b1;
`endif

  // Frame bookkeeping
  logic [KPCNT_W-1:0] kp_count;
  logic               frame_drop;
  logic               trl_pend;
  logic [KPCNT_W-1:0] trl_count;
  logic               trl_drop;

  // Queue interface
  logic               wr_en_c;
  axis_word_t         wr_data_c;
  logic               rd_en_c;
  axis_word_t         nxt_data_c;
  logic               nxt_avail_c;
  logic [CW-1:0]      fifo_count;

  logic               cand_c;
  logic               kp_wr_c;
  logic               kp_drop_c;
  logic               trl_wr_c;
  logic               trl_lost_c;
  logic               frame_end_c;
  logic [KPCNT_W-1:0] cnt_next_c;
  logic               drop_next_c;

  // Write arbitration: the pending trailer owns the single write port, and one
  // entry is always held back from keypoints so the trailer can still land.
  always_comb begin
    cand_c      = ce & kp_vld & kp_flag & in_border_c;
    kp_wr_c     = cand_c & ~trl_pend & (fifo_count < CW'(FIFO_DEPTH - 1));
    kp_drop_c   = cand_c & ~kp_wr_c;
    trl_wr_c    = trl_pend & (fifo_count != CW'(FIFO_DEPTH));
    trl_lost_c  = trl_pend & ~trl_wr_c;
    frame_end_c = ce & kp_frame_end;
    cnt_next_c  = (kp_wr_c && (kp_count != '1)) ? kp_count + KPCNT_W'(1) : kp_count;
    drop_next_c = frame_drop | kp_drop_c;
    wr_en_c     = kp_wr_c | trl_wr_c;
    wr_data_c   = trl_pend ? trl_word(trl_drop, trl_count)
                           : kp_word(kp_score, kp_x_c, kp_y_c);
    rd_en_c     = m_axis_tvalid & m_axis_tready;
  end

  fast_sync_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en_c),
    .wr_data     (wr_data_c),
    .rd_en       (rd_en_c),
    .nxt_data_c  (nxt_data_c),
    .nxt_avail_c (nxt_avail_c),
    .count       (fifo_count)
  );

  // Frame counters, trailer latch and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      kp_count      <= '0;
      frame_drop    <= 1'b0;
      trl_pend      <= 1'b0;
      trl_count     <= '0;
      trl_drop      <= 1'b0;
      tx_overrun    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      trl_pend <= frame_end_c;
      if (frame_end_c) begin
        trl_count  <= cnt_next_c;
        trl_drop   <= drop_next_c;
        kp_count   <= '0;
        frame_drop <= 1'b0;
      end else begin
        kp_count   <= cnt_next_c;
        frame_drop <= drop_next_c;
      end

      if (trl_lost_c) tx_overrun <= 1'b1;

      // The output register mirrors the queue head; with tready low the head
      // does not move, so tdata/tlast stay stable.
      m_axis_tvalid <= nxt_avail_c;
      m_axis_tlast  <= nxt_avail_c & nxt_data_c.last;
      if (nxt_avail_c) m_axis_tdata <= nxt_data_c.data;
    end
  end

endmodule

// File: tb/tb_fast_kp_stream_tx.sv
// tb_fast_kp_stream_tx: directed self-checking bench for fast_kp_stream_tx.
// Beats are collected on the falling edge and compared against hand-built
// expected word lists; a falling-edge monitor also checks that a stalled beat
// holds its value.
module tb_fast_kp_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        kp_vld;
  logic        kp_flag;
  logic [7:0]  kp_score;
  logic [19:0] kp_xy;
  logic        kp_frame_end;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        tx_overrun;

  int checks = 0;
  int passes = 0;

  logic [32:0] got[$];
  logic [32:0] exp_q[$];
  logic        stall = 1'b0;
  logic [32:0] held  = '0;

  fast_kp_stream_tx #(
    .COL_NUM     (640),
    .ROW_NUM     (480),
    .FIFO_DEPTH  (256),
    .SCORE_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .kp_vld        (kp_vld),
    .kp_flag       (kp_flag),
    .kp_score      (kp_score),
    .kp_xy         (kp_xy),
    .kp_frame_end  (kp_frame_end),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .tx_overrun    (tx_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    kp_vld       = 1'b0;
    kp_flag      = 1'b0;
    kp_frame_end = 1'b0;
  endtask

  task automatic drive_kp(input logic [9:0] x, input logic [9:0] y,
                          input logic [7:0] s, input logic fe);
    kp_vld       = 1'b1;
    kp_flag      = 1'b1;
    kp_xy        = {x, y};
    kp_score     = s;
    kp_frame_end = fe;
    cycle();
    idle();
  endtask

  task automatic pulse_fe();
    kp_frame_end = 1'b1;
    cycle();
    idle();
  endtask

  function automatic logic [32:0] kpw(input logic [9:0] x, input logic [9:0] y,
                                      input logic [7:0] s);
    return {1'b0, 4'h0, s, x, y};
  endfunction

  // Wait (bounded) for the expected number of beats, then compare all of them
  task automatic check_beats(input string tag, input int budget);
    int n = 0;
    while (got.size() < exp_q.size() && n < budget) begin
      cycle();
      n++;
    end
    repeat (6) cycle();
    chk({tag, "_nbeats"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp_q[i]));
    end
    got.delete();
    exp_q.delete();
  endtask

  // Beat collector and hold-while-stalled check
  always @(negedge clk) begin
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(held));
      end
      if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tdata});
      stall = m_axis_tvalid && !m_axis_tready;
      held  = {m_axis_tlast, m_axis_tdata};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    ce            = 1'b1;
    kp_score      = '0;
    kp_xy         = '0;
    m_axis_tready = 1'b1;
    idle();
    repeat (3) cycle();
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
    chk("rst_overrun", 64'(tx_overrun), 64'd0);
    rst = 1'b0;
    cycle();

    // Single keypoint: latency N+2, then trailer with count 1
    drive_kp(10'd100, 10'd50, 8'h3C, 1'b0);
    chk("lat_n1_tvalid", 64'(m_axis_tvalid), 64'd0);
    cycle();
    chk("lat_n2_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("lat_n2_tdata", 64'(m_axis_tdata), 64'h03C19032);
    repeat (2) cycle();
    pulse_fe();
    exp_q.push_back(33'h0_03C19032);
    exp_q.push_back(33'h1_F0000001);
    check_beats("single", 50);

    // Empty frame; results with ce=0 or flag=0 are ignored
    ce = 1'b0;
    drive_kp(10'd200, 10'd200, 8'h44, 1'b1);
    ce = 1'b1;
    kp_vld = 1'b1; kp_flag = 1'b0; kp_xy = {10'd30, 10'd30};
    cycle();
    idle();
    pulse_fe();
    exp_q.push_back(33'h1_F0000000);
    check_beats("empty", 50);

    // Backpressure overflow: 300 keypoints, 255 fit, trailer takes the last slot
    m_axis_tready = 1'b0;
    for (int i = 0; i < 300; i++) drive_kp(10'(10 + i), 10'd10, 8'(i), 1'b0);
    pulse_fe();
    repeat (3) cycle();
    chk("ovf_no_overrun_yet", 64'(tx_overrun), 64'd0);
    pulse_fe();
    repeat (3) cycle();
    chk("ovf_trailer_lost", 64'(tx_overrun), 64'd1);
    for (int i = 0; i < 255; i++) exp_q.push_back(kpw(10'(10 + i), 10'd10, 8'(i)));
    exp_q.push_back(33'h1_F80000FF);
    m_axis_tready = 1'b1;
    check_beats("ovf", 600);

    // Border filtering
    drive_kp(10'd1, 10'd50, 8'h11, 1'b0);
    drive_kp(10'd10, 10'd50, 8'h22, 1'b0);
    pulse_fe();
`ifdef FAST_TX_BORDER_MASK_EN
    exp_q.push_back(33'h0_02202832);
    exp_q.push_back(33'h1_F0000001);
`else
    exp_q.push_back(33'h0_01100432);
    exp_q.push_back(33'h0_02202832);
    exp_q.push_back(33'h1_F0000002);
`endif
    check_beats("border", 50);

    // Keypoint with frame_end counts; the next one collides with the trailer
    drive_kp(10'd20, 10'd30, 8'h55, 1'b1);
    drive_kp(10'd21, 10'd30, 8'h56, 1'b0);
    repeat (3) cycle();
    pulse_fe();
    exp_q.push_back(33'h0_0550501E);
    exp_q.push_back(33'h1_F0000001);
    exp_q.push_back(33'h1_F8000000);
    check_beats("same_cycle", 50);

    // Reset with words queued discards everything and clears the overrun flag
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) drive_kp(10'(50 + i), 10'd60, 8'h70, 1'b0);
    repeat (2) cycle();
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("pre_rst_overrun", 64'(tx_overrun), 64'd1);
    rst = 1'b1;
    cycle();
    chk("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("post_rst_overrun", 64'(tx_overrun), 64'd0);
    rst = 1'b0;
    m_axis_tready = 1'b1;
    repeat (10) cycle();
    chk("post_rst_no_beats", 64'(got.size()), 64'd0);
    drive_kp(10'd200, 10'd100, 8'h99, 1'b0);
    pulse_fe();
    exp_q.push_back(33'h0_09932064);
    exp_q.push_back(33'h1_F0000001);
    check_beats("after_rst", 50);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
